// File: rtl/rggen_axi4lite_bridge_if.sv
// Shared access/status codes plus the AXI4-Lite and register-bus interfaces
// used by rggen_axi4lite_bridge.
package rggen_rtl_pkg;
  localparam logic [1:0] RGGEN_READ         = 2'b10;
  localparam logic [1:0] RGGEN_POSTED_WRITE = 2'b01;
  localparam logic [1:0] RGGEN_WRITE        = 2'b11;
  localparam logic [1:0] RGGEN_OKAY         = 2'b00;
  localparam logic [1:0] RGGEN_EXOKAY       = 2'b01;
  localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;
endpackage

interface rggen_axi4lite_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     awvalid;
  logic                     awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [BUS_WIDTH-1:0]     rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  logic [1:0]               access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave to single-outstanding rggen_bus_if bridge.
// Define RGGEN_AXI4LITE_WRITE_FIRST_EN to make writes always win read/write contention.
module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
)(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_axi4lite_if.slave      axi_if,
  rggen_bus_if.master          bus_if
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e                   state_r;
  logic                     grant_write_r;
  logic                     aw_held_r;
  logic                     w_held_r;
  logic                     ar_held_r;
  logic [ADDRESS_WIDTH-1:0] aw_addr_r;
  logic [ADDRESS_WIDTH-1:0] ar_addr_r;
  logic [BUS_WIDTH-1:0]     wdata_r;
  logic [STRB_WIDTH-1:0]    wstrb_r;
  logic                     bus_valid_r;
  logic [1:0]               bus_access_r;
  logic [ADDRESS_WIDTH-1:0] bus_address_r;
  logic [BUS_WIDTH-1:0]     bus_write_data_r;
  logic [STRB_WIDTH-1:0]    bus_strobe_r;
  logic                     bvalid_r;
  logic                     rvalid_r;
  logic [1:0]               bresp_r;
  logic [1:0]               rresp_r;
  logic [BUS_WIDTH-1:0]     rdata_r;
  logic                     write_pend_s;
  logic                     read_pend_s;
  logic                     pick_write_s;
  logic                     bus_done_s;
  logic                     unused_s;
`ifndef RGGEN_AXI4LITE_WRITE_FIRST_EN
  logic                     last_grant_write_r;
`endif

  assign unused_s = ^{axi_if.awprot, axi_if.arprot};

  assign axi_if.awready     = !aw_held_r;
  assign axi_if.wready      = !w_held_r;
  assign axi_if.arready     = !ar_held_r;
  assign axi_if.bvalid      = bvalid_r;
  assign axi_if.bresp       = bresp_r;
  assign axi_if.rvalid      = rvalid_r;
  assign axi_if.rresp       = rresp_r;
  assign axi_if.rdata       = rdata_r;
  assign bus_if.valid       = bus_valid_r;
  assign bus_if.access      = bus_access_r;
  assign bus_if.address     = bus_address_r;
  assign bus_if.write_data  = bus_write_data_r;
  assign bus_if.strobe      = bus_strobe_r;

  // Pending requests and the arbitration decision taken in IDLE
  always_comb begin
    write_pend_s = aw_held_r && w_held_r;
    read_pend_s  = ar_held_r;
    bus_done_s   = (state_r == BUS) && bus_if.ready;
`ifdef RGGEN_AXI4LITE_WRITE_FIRST_EN
    pick_write_s = write_pend_s;
`else
    pick_write_s = write_pend_s && (!read_pend_s || !last_grant_write_r);
`endif
  end

  // Per-channel hold registers; released when the bus accepts the granted request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      ar_held_r <= 1'b0;
      aw_addr_r <= '0;
      ar_addr_r <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
    end else begin
      if (axi_if.awvalid && !aw_held_r) begin
        aw_held_r <= 1'b1;
        aw_addr_r <= axi_if.awaddr;
      end else if (bus_done_s && grant_write_r) begin
        aw_held_r <= 1'b0;
      end
      if (axi_if.wvalid && !w_held_r) begin
        w_held_r <= 1'b1;
        wdata_r  <= axi_if.wdata;
        wstrb_r  <= axi_if.wstrb;
      end else if (bus_done_s && grant_write_r) begin
        w_held_r <= 1'b0;
      end
      if (axi_if.arvalid && !ar_held_r) begin
        ar_held_r <= 1'b1;
        ar_addr_r <= axi_if.araddr;
      end else if (bus_done_s && !grant_write_r) begin
        ar_held_r <= 1'b0;
      end
    end
  end

  // Transaction FSM: grant, drive the bus, then return the AXI response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r            <= IDLE;
      grant_write_r      <= 1'b0;
      bus_valid_r        <= 1'b0;
      bus_access_r       <= RGGEN_READ;
      bus_address_r      <= '0;
      bus_write_data_r   <= '0;
      bus_strobe_r       <= '0;
      bvalid_r           <= 1'b0;
      rvalid_r           <= 1'b0;
      bresp_r            <= 2'b00;
      rresp_r            <= 2'b00;
      rdata_r            <= '0;
`ifndef RGGEN_AXI4LITE_WRITE_FIRST_EN
      last_grant_write_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (write_pend_s || read_pend_s) begin
            state_r       <= BUS;
            bus_valid_r   <= 1'b1;
            grant_write_r <= pick_write_s;
            if (pick_write_s) begin
              bus_access_r     <= RGGEN_WRITE;
              bus_address_r    <= aw_addr_r;
              bus_write_data_r <= wdata_r;
              bus_strobe_r     <= wstrb_r;
            end else begin
              bus_access_r     <= RGGEN_READ;
              bus_address_r    <= ar_addr_r;
              bus_write_data_r <= '0;
              bus_strobe_r     <= '1;
            end
          end
        end
        BUS: begin
          if (bus_if.ready) begin
            bus_valid_r <= 1'b0;
            state_r     <= RESP;
`ifndef RGGEN_AXI4LITE_WRITE_FIRST_EN
            last_grant_write_r <= grant_write_r;
`endif
            if (grant_write_r) begin
              bvalid_r <= 1'b1;
              bresp_r  <= bus_if.status;
            end else begin
              rvalid_r <= 1'b1;
              rresp_r  <= bus_if.status;
              rdata_r  <= bus_if.read_data;
            end
          end
        end
        RESP: begin
          if ((bvalid_r && axi_if.bready) || (rvalid_r && axi_if.rready)) begin
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          bus_valid_r <= 1'b0;
          bvalid_r    <= 1'b0;
          rvalid_r    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed self-checking bench for rggen_axi4lite_bridge with a simple bus slave model.
module tb_rggen_axi4lite_bridge;
  import rggen_rtl_pkg::*;

  logic i_clk;
  logic i_rst_n;
  logic ready_en;
  int   tests_run;
  int   tests_failed;
  int   b_cnt;
  int   r_cnt;
  int   g_cnt;
  logic [1:0] grant_log [0:63];

  rggen_axi4lite_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) axi ();
  rggen_bus_if      #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus ();

  rggen_axi4lite_bridge #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .axi_if  (axi),
    .bus_if  (bus)
  );

  assign bus.ready = bus.valid & ready_en;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) begin
    if (axi.bvalid && axi.bready) b_cnt <= b_cnt + 1;
    if (axi.rvalid && axi.rready) r_cnt <= r_cnt + 1;
    if (bus.valid && bus.ready) begin
      grant_log[g_cnt & 63] <= bus.access;
      g_cnt <= g_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_now;
    bit w_now;
    axi.awaddr  = addr;
    axi.awvalid = 1'b1;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.wvalid  = 1'b1;
    for (int i = 0; i < 200 && !(aw_done && w_done); i++) begin
      aw_now = axi.awvalid && axi.awready;
      w_now  = axi.wvalid && axi.wready;
      tick();
      if (aw_now) begin axi.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_now)  begin axi.wvalid  = 1'b0; w_done  = 1'b1; end
    end
    check_eq("wr_handshake", {63'd0, aw_done && w_done}, 64'd1);
  endtask

  task automatic axi_read(input logic [7:0] addr);
    bit ar_done = 1'b0;
    bit ar_now;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    for (int i = 0; i < 200 && !ar_done; i++) begin
      ar_now = axi.arready;
      tick();
      if (ar_now) begin axi.arvalid = 1'b0; ar_done = 1'b1; end
    end
    check_eq("rd_handshake", {63'd0, ar_done}, 64'd1);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int b0;
    int r0;
    int g0;
    bit done;
    logic [1:0] exp_acc;
    tests_run = 0; tests_failed = 0;
    b_cnt = 0; r_cnt = 0; g_cnt = 0;
    ready_en = 1'b1;
    axi.awvalid = 1'b0; axi.awaddr = 8'h00; axi.awprot = 3'b000;
    axi.wvalid = 1'b0; axi.wdata = 32'h0; axi.wstrb = 4'h0; axi.bready = 1'b1;
    axi.arvalid = 1'b0; axi.araddr = 8'h00; axi.arprot = 3'b000; axi.rready = 1'b1;
    bus.status = RGGEN_OKAY; bus.read_data = 32'h0;
    i_rst_n = 1'b0;
    tick();
    tick();
    // Reset state
    check_eq("rst_awready", {63'd0, axi.awready}, 64'd1);
    check_eq("rst_wready",  {63'd0, axi.wready},  64'd1);
    check_eq("rst_arready", {63'd0, axi.arready}, 64'd1);
    check_eq("rst_bvalid",  {63'd0, axi.bvalid},  64'd0);
    check_eq("rst_rvalid",  {63'd0, axi.rvalid},  64'd0);
    check_eq("rst_busvalid",{63'd0, bus.valid},   64'd0);
    check_eq("rst_resp",    {60'd0, axi.bresp, axi.rresp}, 64'd0);
    check_eq("rst_rdata",   {32'd0, axi.rdata},   64'd0);
    i_rst_n = 1'b1;
    tick();

    // Single write with same-cycle bus ready
    axi.awaddr = 8'h10; axi.awvalid = 1'b1;
    axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check_eq("w1_awready_low", {63'd0, axi.awready}, 64'd0);
    check_eq("w1_n1_busvalid", {63'd0, bus.valid}, 64'd0);
    tick();
    check_eq("w1_busvalid", {63'd0, bus.valid}, 64'd1);
    check_eq("w1_access",   {62'd0, bus.access}, {62'd0, RGGEN_WRITE});
    check_eq("w1_addr",     {56'd0, bus.address}, 64'h10);
    check_eq("w1_strobe",   {60'd0, bus.strobe}, 64'hF);
    check_eq("w1_wdata",    {32'd0, bus.write_data}, 64'h1234_5678);
    tick();
    check_eq("w1_bvalid",   {63'd0, axi.bvalid}, 64'd1);
    check_eq("w1_bresp",    {62'd0, axi.bresp}, 64'd0);
    check_eq("w1_busidle",  {63'd0, bus.valid}, 64'd0);
    tick();
    check_eq("w1_bvalid_drop", {63'd0, axi.bvalid}, 64'd0);

    // W three cycles ahead of AW
    b0 = b_cnt;
    axi.wdata = 32'hA5A5_0F0F; axi.wstrb = 4'h3; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    check_eq("wfirst_wready", {63'd0, axi.wready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wfirst_no_bus", {63'd0, bus.valid}, 64'd0);
    end
    axi.awaddr = 8'h20; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    tick();
    check_eq("wfirst_busvalid", {63'd0, bus.valid}, 64'd1);
    check_eq("wfirst_addr",   {56'd0, bus.address}, 64'h20);
    check_eq("wfirst_strobe", {60'd0, bus.strobe}, 64'h3);
    check_eq("wfirst_wdata",  {32'd0, bus.write_data}, 64'hA5A5_0F0F);
    tick();
    check_eq("wfirst_bvalid", {63'd0, axi.bvalid}, 64'd1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("wfirst_single_b", 64'(b_cnt - b0), 64'd1);

    // Read with SLAVE_ERROR status
    bus.status = RGGEN_SLAVE_ERROR; bus.read_data = 32'hDEAD_BEEF;
    axi.araddr = 8'h04; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    check_eq("rd_arready_low", {63'd0, axi.arready}, 64'd0);
    tick();
    check_eq("rd_busvalid", {63'd0, bus.valid}, 64'd1);
    check_eq("rd_access",   {62'd0, bus.access}, {62'd0, RGGEN_READ});
    check_eq("rd_addr",     {56'd0, bus.address}, 64'h04);
    check_eq("rd_strobe",   {60'd0, bus.strobe}, 64'hF);
    check_eq("rd_wdata",    {32'd0, bus.write_data}, 64'h0);
    tick();
    check_eq("rd_rvalid",   {63'd0, axi.rvalid}, 64'd1);
    check_eq("rd_rresp",    {62'd0, axi.rresp}, 64'h2);
    check_eq("rd_rdata",    {32'd0, axi.rdata}, 64'hDEAD_BEEF);
    tick();
    check_eq("rd_rvalid_drop", {63'd0, axi.rvalid}, 64'd0);
    bus.status = RGGEN_OKAY; bus.read_data = 32'h0;

    // Four writes and four reads contending from reset
    do_reset();
    b0 = b_cnt; r0 = r_cnt; g0 = g_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) axi_write(8'h40 + 8'(i * 4), 32'h1000_0000 + 32'(i), 4'hF);
      end
      begin
        for (int j = 0; j < 4; j++) axi_read(8'h80 + 8'(j * 4));
      end
    join
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      done = (b_cnt - b0 == 4) && (r_cnt - r0 == 4);
    end
    check_eq("arb_b_count", 64'(b_cnt - b0), 64'd4);
    check_eq("arb_r_count", 64'(r_cnt - r0), 64'd4);
    for (int i = 0; i < 8; i++) begin
`ifdef RGGEN_AXI4LITE_WRITE_FIRST_EN
      exp_acc = (i < 4) ? RGGEN_WRITE : RGGEN_READ;
`else
      exp_acc = (i % 2 == 0) ? RGGEN_WRITE : RGGEN_READ;
`endif
      check_eq($sformatf("arb_grant%0d", i), {62'd0, grant_log[(g0 + i) & 63]}, {62'd0, exp_acc});
    end

    // Stalled B channel with a read buffered behind it
    axi.bready = 1'b0;
    axi.awaddr = 8'h30; axi.awvalid = 1'b1;
    axi.wdata = 32'h0BAD_F00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tick();
    tick();
    axi.araddr = 8'h08; axi.arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bstall_bvalid", {63'd0, axi.bvalid}, 64'd1);
      check_eq("bstall_no_bus", {63'd0, bus.valid}, 64'd0);
      tick();
      if (i == 0) begin
        axi.arvalid = 1'b0;
        check_eq("bstall_arready", {63'd0, axi.arready}, 64'd0);
      end
    end
    axi.bready = 1'b1;
    tick();
    check_eq("bstall_bdone", {63'd0, axi.bvalid}, 64'd0);
    check_eq("bstall_idle",  {63'd0, bus.valid}, 64'd0);
    tick();
    check_eq("bstall_rd_valid",  {63'd0, bus.valid}, 64'd1);
    check_eq("bstall_rd_access", {62'd0, bus.access}, {62'd0, RGGEN_READ});
    check_eq("bstall_rd_addr",   {56'd0, bus.address}, 64'h08);
    tick();
    check_eq("bstall_rvalid", {63'd0, axi.rvalid}, 64'd1);
    tick();

    // Reset in the middle of a bus transaction
    ready_en = 1'b0;
    axi.awaddr = 8'h50; axi.awvalid = 1'b1;
    axi.wdata = 32'h5555_AAAA; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    tick();
    tick();
    check_eq("abort_pre_valid", {63'd0, bus.valid}, 64'd1);
    b0 = b_cnt; r0 = r_cnt; g0 = g_cnt;
    i_rst_n = 1'b0;
    #1;
    check_eq("abort_busvalid", {63'd0, bus.valid}, 64'd0);
    check_eq("abort_bvalid",   {63'd0, axi.bvalid}, 64'd0);
    check_eq("abort_rvalid",   {63'd0, axi.rvalid}, 64'd0);
    check_eq("abort_readies",  {61'd0, axi.awready, axi.wready, axi.arready}, 64'h7);
    tick();
    tick();
    i_rst_n = 1'b1;
    ready_en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check_eq("abort_no_b",     64'(b_cnt - b0), 64'd0);
    check_eq("abort_no_r",     64'(r_cnt - r0), 64'd0);
    check_eq("abort_no_grant", 64'(g_cnt - g0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
